// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment checks, byte-lane steering and load extension
// in front of a word-addressed, variable-latency data memory with a bounded wait.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_err;
    logic        w_legal, w_expire;

    function automatic logic f_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~off[0];
            2'd2:    ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        if (f3 == 3'd6 || (we && f3[2]))
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign w_legal  = f_legal(req_we, req_funct3, req_addr[1:0]);
    // Counter spans ISSUE and WAIT together; progress wins over expiry on the same cycle.
    assign w_expire = (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_legal ? S_ISSUE : S_DONE;
            S_ISSUE: begin
                if (mem_ready)
                    w_next = r_we ? S_DONE : S_WAIT;
                else if (w_expire)
                    w_next = S_DONE;
            end
            S_WAIT:  if (mem_rvalid || w_expire) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (req_valid && !w_legal) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mem_ready && r_we) begin
                        r_err   <= 1'b0;
                        r_rdata <= 32'd0;
                    end else if (!mem_ready && w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mem_rvalid) begin
                        r_err   <= 1'b0;
                        r_rdata <= f_load(r_f3, r_addr[1:0], mem_rdata);
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are forced to zero whenever no request is presented.
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_valid  = (r_state == S_ISSUE);
    assign mem_we     = mem_valid & r_we;
    assign mem_be     = mem_valid ? f_be(r_f3[1:0], r_addr[1:0]) : 4'd0;
    assign mem_addr   = mem_valid ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = mem_valid ? f_store(r_f3[1:0], r_wdata) : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: default instance for the main paths,
// a TIMEOUT=4 instance for the bounded-wait abort.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_t, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_err, mem_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        req_ready_t, resp_valid_t, resp_err_t, mem_valid_t, mem_we_t;
    logic [31:0] resp_rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_be_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_ready(req_ready_t),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
        .mem_valid(mem_valid_t), .mem_ready(mem_ready), .mem_we(mem_we_t), .mem_be(mem_be_t),
        .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access on dut with a responsive memory; mem_ready after rdly stalled cycles.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mdata, input int rdly,
                          output logic [31:0] o_rd, output logic o_err, output int lat,
                          output int nvalid, output logic [3:0] be0, output logic [31:0] addr0,
                          output logic [31:0] wd0, output logic we0, output logic stable,
                          output logic rdy_done);
        int   hold;
        logic acc;
        hold = 0; acc = 1'b0; nvalid = 0; lat = -1; o_rd = '0; o_err = 1'b0;
        be0 = '0; addr0 = '0; wd0 = '0; we0 = 1'b0; stable = 1'b1; rdy_done = 1'b1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                o_rd = resp_rdata; o_err = resp_err; rdy_done = req_ready; lat = c;
            end else begin
                if (mem_valid) begin
                    if (nvalid == 0) begin
                        be0 = mem_be; addr0 = mem_addr; wd0 = mem_wdata; we0 = mem_we;
                    end else if (mem_be !== be0 || mem_addr !== addr0 || mem_wdata !== wd0 || mem_we !== we0) begin
                        stable = 1'b0;
                    end
                    nvalid++;
                    if (hold >= rdly) begin
                        mem_ready = 1'b1;
                        acc = 1'b1;
                    end
                    hold++;
                end else if (acc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mdata;
                    acc = 1'b0;
                end
                tick();
            end
        end
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        if (lat >= 0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if ({resp_valid, resp_err, mem_valid, mem_we} !== 4'b0) begin n_errors++; $display("FAIL reset_ctl: got %b want 0000", {resp_valid, resp_err, mem_valid, mem_we}); end
        n_checks++; if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== 100'd0) begin n_errors++; $display("FAIL reset_data: be %h addr %h wd %h rd %h want 0", mem_be, mem_addr, mem_wdata, resp_rdata); end
        reset = 1'b0;
        tick();
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: ready %b resp %b want 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_lw();
        logic [31:0] rd, a0, w0; logic er, we0, st, rdy; int lat, nv; logic [3:0] be0;
        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_errors++; $display("FAIL lw_data: got %h err %b want deadbeef 0", rd, er); end
        n_checks++; if (be0 !== 4'b1111 || a0 !== 32'h100 || we0 !== 1'b0 || nv !== 1) begin n_errors++; $display("FAIL lw_mem: be %b addr %h we %b n %0d want 1111 100 0 1", be0, a0, we0, nv); end
        n_checks++; if (resp_rdata !== 32'hDEADBEEF || resp_valid !== 1'b0) begin n_errors++; $display("FAIL lw_hold: rd %h valid %b want deadbeef 0", resp_rdata, resp_valid); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd, a0, w0; logic er, we0, st, rdy; int lat, nv; logic [3:0] be0;
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rd !== 32'hFFFFFF80 || be0 !== 4'b1000 || a0 !== 32'h100) begin n_errors++; $display("FAIL lb_103: rd %h be %b addr %h want ffffff80 1000 100", rd, be0, a0); end
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rd !== 32'h00000080 || er !== 1'b0) begin n_errors++; $display("FAIL lbu_103: rd %h err %b want 00000080 0", rd, er); end
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80112233, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rd !== 32'h00008011 || be0 !== 4'b1100) begin n_errors++; $display("FAIL lhu_102: rd %h be %b want 00008011 1100", rd, be0); end
        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rd !== 32'hFFFF8011) begin n_errors++; $display("FAIL lh_102: rd %h want ffff8011", rd); end
        access(1'b0, 3'd0, 32'h100, 32'h0, 32'h80112233, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rd !== 32'h00000033 || be0 !== 4'b0001) begin n_errors++; $display("FAIL lb_100: rd %h be %b want 00000033 0001", rd, be0); end
    endtask

    task automatic test_store();
        logic [31:0] rd, a0, w0; logic er, we0, st, rdy; int lat, nv; logic [3:0] be0;
        access(1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0, 3, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (be0 !== 4'b0010 || w0 !== 32'hA5A5A5A5 || a0 !== 32'h100 || we0 !== 1'b1) begin n_errors++; $display("FAIL sb_lanes: be %b wd %h addr %h we %b want 0010 a5a5a5a5 100 1", be0, w0, a0, we0); end
        n_checks++; if (st !== 1'b1 || nv !== 4) begin n_errors++; $display("FAIL sb_stall: stable %b cycles %0d want 1 4", st, nv); end
        n_checks++; if (lat !== 5 || er !== 1'b0 || rd !== 32'd0) begin n_errors++; $display("FAIL sb_resp: lat %0d err %b rd %h want 5 0 0", lat, er, rd); end
        access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (be0 !== 4'b1100 || w0 !== 32'hABCDABCD || lat !== 2) begin n_errors++; $display("FAIL sh_102: be %b wd %h lat %0d want 1100 abcdabcd 2", be0, w0, lat); end
        access(1'b1, 3'd2, 32'h104, 32'h01020304, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (be0 !== 4'b1111 || w0 !== 32'h01020304 || a0 !== 32'h104) begin n_errors++; $display("FAIL sw_104: be %b wd %h addr %h want 1111 01020304 104", be0, w0, a0); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, a0, w0; logic er, we0, st, rdy; int lat, nv; logic [3:0] be0;
        access(1'b0, 3'd1, 32'h101, 32'h0, 32'h55555555, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat < 0 || er !== 1'b1 || rd !== 32'd0 || nv !== 0) begin n_errors++; $display("FAIL lh_misaligned: lat %0d err %b rd %h memv %0d want err 1 rd 0 memv 0", lat, er, rd, nv); end
        access(1'b1, 3'd2, 32'h102, 32'h11111111, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat < 0 || er !== 1'b1 || rd !== 32'd0 || nv !== 0) begin n_errors++; $display("FAIL sw_misaligned: lat %0d err %b rd %h memv %0d want err 1 rd 0 memv 0", lat, er, rd, nv); end
        access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat < 0 || er !== 1'b1 || nv !== 0) begin n_errors++; $display("FAIL funct3_3: lat %0d err %b memv %0d want err 1 memv 0", lat, er, nv); end
        access(1'b0, 3'd6, 32'h100, 32'h0, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat < 0 || er !== 1'b1 || nv !== 0) begin n_errors++; $display("FAIL funct3_6: lat %0d err %b memv %0d want err 1 memv 0", lat, er, nv); end
        access(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat < 0 || er !== 1'b1 || nv !== 0) begin n_errors++; $display("FAIL store_f3_4: lat %0d err %b memv %0d want err 1 memv 0", lat, er, nv); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a0, w0; logic er, we0, st, rdy; int lat, nv; logic [3:0] be0;
        access(1'b1, 3'd2, 32'h200, 32'hCAFE0001, 32'h0, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (rdy !== 1'b0) begin n_errors++; $display("FAIL done_ready: got %b want 0", rdy); end
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL idle_after_done: got %b want 1", req_ready); end
        access(1'b0, 3'd2, 32'h204, 32'h0, 32'h12345678, 0, rd, er, lat, nv, be0, a0, w0, we0, st, rdy);
        n_checks++; if (lat !== 3 || rd !== 32'h12345678 || er !== 1'b0) begin n_errors++; $display("FAIL b2b_load: lat %0d rd %h err %b want 3 12345678 0", lat, rd, er); end
    endtask

    task automatic test_timeout();
        int n; logic got; logic [31:0] rd; logic er;
        n = 0; got = 1'b0; rd = '1; er = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; req_valid_t = 1'b1;
        tick();
        req_valid_t = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (resp_valid_t) begin
                got = 1'b1; rd = resp_rdata_t; er = resp_err_t;
            end else begin
                if (mem_valid_t) n++;
                tick();
            end
        end
        n_checks++; if (got !== 1'b1 || n !== 4) begin n_errors++; $display("FAIL timeout_len: resp %b memv_cycles %0d want 1 4", got, n); end
        n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_errors++; $display("FAIL timeout_resp: err %b rd %h want 1 0", er, rd); end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        n_checks++; if (resp_valid_t !== 1'b0 || req_ready_t !== 1'b1 || resp_rdata_t !== 32'd0) begin n_errors++; $display("FAIL stray_rvalid: valid %b ready %b rd %h want 0 1 0", resp_valid_t, req_ready_t, resp_rdata_t); end
    endtask

    task automatic test_reset_in_wait();
        mem_ready = 1'b1;
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (mem_valid !== 1'b1) begin n_errors++; $display("FAIL rw_issue: memv %b want 1", mem_valid); end
        tick();
        mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_valid !== 1'b0 || resp_rdata !== 32'd0) begin n_errors++; $display("FAIL rw_abort: ready %b resp %b memv %b rd %h want 1 0 0 0", req_ready, resp_valid, mem_valid, resp_rdata); end
        mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_rvalid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL rw_no_resp: resp %b ready %b want 0 1", resp_valid, req_ready); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid_t = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
